pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_fwd_select.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

   localparam int SLOT_REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [SLOT_REG_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // One shadow-pipeline entry mirroring what the real pipeline register holds.
   typedef struct packed {
      logic [SLOT_REG_W-1:0] rs;
      logic [SLOT_REG_W-1:0] rt;
      logic [SLOT_REG_W-1:0] dst;
      logic                  regwrite;
      logic                  memread;
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Picks the forwarding source for one EX operand; the newest producer (MEM) wins over WB.
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [SLOT_REG_W-1:0] ex_src,
   input  slot_t                 mem_slot,
   input  slot_t                 wb_slot,
   output logic [1:0]            sel
);

   logic unused_slot_bits;
   assign unused_slot_bits = ^{mem_slot.rs, mem_slot.rt, mem_slot.memread,
                               wb_slot.rs, wb_slot.rt, wb_slot.memread};

   // Register 0 is hardwired, so a write to it must never be forwarded.
   always_comb begin
      sel = FWD_RF;
      if (mem_slot.regwrite && (mem_slot.dst != REG_ZERO) && (mem_slot.dst == ex_src)) begin
         sel = FWD_MEM;
      end else if (wb_slot.regwrite && (wb_slot.dst != REG_ZERO) && (wb_slot.dst == ex_src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM/WB slots, operand forwarding selects,
// load-use stalls and taken-branch flushes for the five-stage pipeline.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_DEPTH = 2,
   parameter int REG_W       = SLOT_REG_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic [REG_W-1:0] id_dst_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             ex_branch_taken_i,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             idex_bubble_o,
   output logic             flush_o
);

   state_t     state;
   logic [2:0] count;
   slot_t      ex_slot;
   slot_t      mem_slot;
   slot_t      wb_slot;
   slot_t      id_slot;

   logic branch_flush;
   logic in_flush;
   logic load_hit;
   logic stall;

   assign id_slot = '{rs: id_rs_i, rt: id_rt_i, dst: id_dst_i,
                      regwrite: id_regwrite_i, memread: id_memread_i};

   assign in_flush     = (state == ST_FLUSH);
   assign branch_flush = (state == ST_RUN) && ex_branch_taken_i;

   // A load in EX whose result is needed by ID cannot be forwarded in time; hold ID one cycle.
   assign load_hit = id_valid_i && ex_slot.memread && ex_slot.regwrite &&
                     (ex_slot.dst != REG_ZERO) &&
                     ((ex_slot.dst == id_rs_i) || (ex_slot.dst == id_rt_i));

   // A flush discards the ID instruction anyway, so it overrides any stall.
   assign stall = load_hit && !branch_flush && !in_flush;

   assign flush_o       = branch_flush || in_flush;
   assign pc_write_o    = !stall;
   assign ifid_write_o  = !stall;
   assign idex_bubble_o = stall || flush_o;

   // Shadow pipeline advance plus the flush sequencer; the counter holds the remaining flush cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_slot  <= SLOT_BUBBLE;
         mem_slot <= SLOT_BUBBLE;
         wb_slot  <= SLOT_BUBBLE;
         state    <= ST_RUN;
         count    <= 3'd0;
      end else begin
         ex_slot  <= (!id_valid_i || idex_bubble_o) ? SLOT_BUBBLE : id_slot;
         mem_slot <= ex_slot;
         wb_slot  <= mem_slot;
         case (state)
            ST_RUN: begin
               if (ex_branch_taken_i && (FLUSH_DEPTH > 1)) begin
                  state <= ST_FLUSH;
                  count <= 3'(FLUSH_DEPTH - 1);
               end
            end
            ST_FLUSH: begin
               if (count <= 3'd1) begin
                  state <= ST_RUN;
                  count <= 3'd0;
               end else begin
                  count <= count - 3'd1;
               end
            end
            default: begin
               state <= ST_RUN;
               count <= 3'd0;
            end
         endcase
      end
   end

   fwd_select u_fwd_a (
      .ex_src   (ex_slot.rs),
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .sel      (fwd_a_sel_o)
   );

   fwd_select u_fwd_b (
      .ex_src   (ex_slot.rt),
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot),
      .sel      (fwd_b_sel_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instruction sequences with hand-derived controls.
module tb_pipe_hazard_ctrl;

   logic       clk_i;
   logic       rst_i;
   logic       id_valid_i;
   logic [4:0] id_rs_i;
   logic [4:0] id_rt_i;
   logic [4:0] id_dst_i;
   logic       id_regwrite_i;
   logic       id_memread_i;
   logic       ex_branch_taken_i;
   logic [1:0] fwd_a_sel_o;
   logic [1:0] fwd_b_sel_o;
   logic       pc_write_o;
   logic       ifid_write_o;
   logic       idex_bubble_o;
   logic       flush_o;

   int checkCount = 0;
   int errorCount = 0;

   pipe_hazard_ctrl #(.FLUSH_DEPTH(2), .REG_W(5)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .id_valid_i        (id_valid_i),
      .id_rs_i           (id_rs_i),
      .id_rt_i           (id_rt_i),
      .id_dst_i          (id_dst_i),
      .id_regwrite_i     (id_regwrite_i),
      .id_memread_i      (id_memread_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .fwd_a_sel_o       (fwd_a_sel_o),
      .fwd_b_sel_o       (fwd_b_sel_o),
      .pc_write_o        (pc_write_o),
      .ifid_write_o      (ifid_write_o),
      .idex_bubble_o     (idex_bubble_o),
      .flush_o           (flush_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drives the ID-stage instruction and branch flag, then lets combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dst, input logic rw, input logic mr,
                                input logic br);
      id_valid_i        = v;
      id_rs_i           = rs;
      id_rt_i           = rt;
      id_dst_i          = dst;
      id_regwrite_i     = rw;
      id_memread_i      = mr;
      ex_branch_taken_i = br;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      checkOutput("rst_fwd_b", 8'(fwd_b_sel_o), 8'd0);
      checkOutput("rst_pc_write", 8'(pc_write_o), 8'd1);
      checkOutput("rst_ifid_write", 8'(ifid_write_o), 8'd1);
      checkOutput("rst_bubble", 8'(idex_bubble_o), 8'd0);
      checkOutput("rst_flush", 8'(flush_o), 8'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Back-to-back dependency: add $5 then sub $5,$5
      applyStimulus(1, 1, 2, 5, 1, 0, 0);
      checkOutput("add5_no_stall", 8'(pc_write_o), 8'd1);
      stepClock();
      applyStimulus(1, 5, 5, 6, 1, 0, 0);
      stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("mem_fwd_a", 8'(fwd_a_sel_o), 8'd2);
      checkOutput("mem_fwd_b", 8'(fwd_b_sel_o), 8'd2);
      stepClock();

      // One NOP between producer ($8) and consumer
      applyStimulus(1, 1, 2, 8, 1, 0, 0);
      checkOutput("bubble_in_ex_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      stepClock();
      applyStimulus(1, 8, 8, 9, 1, 0, 0);
      stepClock();

      // Two writes to $7 then read: the newer one in MEM wins
      applyStimulus(1, 1, 2, 7, 1, 0, 0);
      checkOutput("wb_fwd_a", 8'(fwd_a_sel_o), 8'd1);
      checkOutput("wb_fwd_b", 8'(fwd_b_sel_o), 8'd1);
      stepClock();
      applyStimulus(1, 1, 2, 7, 1, 0, 0);
      stepClock();
      applyStimulus(1, 7, 1, 10, 1, 0, 0);
      stepClock();

      // Write $0 then read $0: never forwarded
      applyStimulus(1, 1, 2, 0, 1, 0, 0);
      checkOutput("newest_fwd_a", 8'(fwd_a_sel_o), 8'd2);
      checkOutput("newest_fwd_b_rf", 8'(fwd_b_sel_o), 8'd0);
      stepClock();
      applyStimulus(1, 0, 0, 11, 1, 0, 0);
      stepClock();

      // lw $4 followed by a consumer of $4
      applyStimulus(1, 2, 0, 4, 1, 1, 0);
      checkOutput("r0_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      checkOutput("r0_fwd_b", 8'(fwd_b_sel_o), 8'd0);
      stepClock();
      applyStimulus(1, 1, 4, 12, 1, 0, 0);
      checkOutput("lu_pc_write", 8'(pc_write_o), 8'd0);
      checkOutput("lu_ifid_write", 8'(ifid_write_o), 8'd0);
      checkOutput("lu_bubble", 8'(idex_bubble_o), 8'd1);
      checkOutput("lu_flush", 8'(flush_o), 8'd0);
      stepClock();
      applyStimulus(1, 1, 4, 12, 1, 0, 0);
      checkOutput("lu_release_pc_write", 8'(pc_write_o), 8'd1);
      checkOutput("lu_release_bubble", 8'(idex_bubble_o), 8'd0);
      stepClock();

      // Taken branch: two flush cycles, second-cycle branch ignored, squashed writes not forwarded
      applyStimulus(1, 1, 2, 13, 1, 0, 1);
      checkOutput("lu_fwd_b", 8'(fwd_b_sel_o), 8'd1);
      checkOutput("lu_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      checkOutput("br_flush_c1", 8'(flush_o), 8'd1);
      checkOutput("br_pc_write_c1", 8'(pc_write_o), 8'd1);
      stepClock();
      applyStimulus(1, 1, 2, 14, 1, 0, 1);
      checkOutput("br_flush_c2", 8'(flush_o), 8'd1);
      checkOutput("br_bubble_c2", 8'(idex_bubble_o), 8'd1);
      checkOutput("br_pc_write_c2", 8'(pc_write_o), 8'd1);
      stepClock();
      applyStimulus(1, 13, 14, 15, 1, 0, 0);
      checkOutput("br_flush_c3", 8'(flush_o), 8'd0);
      checkOutput("br_bubble_c3", 8'(idex_bubble_o), 8'd0);
      stepClock();
      applyStimulus(1, 2, 0, 4, 1, 1, 0);
      checkOutput("squash_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      checkOutput("squash_fwd_b", 8'(fwd_b_sel_o), 8'd0);
      checkOutput("br_flush_c4", 8'(flush_o), 8'd0);
      stepClock();

      // Branch in same cycle as a load-use hazard
      applyStimulus(1, 4, 0, 16, 1, 0, 1);
      checkOutput("brlu_flush", 8'(flush_o), 8'd1);
      checkOutput("brlu_pc_write", 8'(pc_write_o), 8'd1);
      checkOutput("brlu_ifid_write", 8'(ifid_write_o), 8'd1);
      stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("brlu_flush_c2", 8'(flush_o), 8'd1);
      stepClock();

      // Reset pulsed between edges while a forward and a flush are active
      applyStimulus(1, 1, 2, 3, 1, 0, 0);
      checkOutput("brlu_flush_c3", 8'(flush_o), 8'd0);
      stepClock();
      applyStimulus(1, 3, 1, 17, 1, 0, 0);
      stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("pre_rst_fwd_a", 8'(fwd_a_sel_o), 8'd2);
      checkOutput("pre_rst_flush", 8'(flush_o), 8'd1);
      ex_branch_taken_i = 1'b0;
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("mid_rst_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      checkOutput("mid_rst_fwd_b", 8'(fwd_b_sel_o), 8'd0);
      checkOutput("mid_rst_flush", 8'(flush_o), 8'd0);
      checkOutput("mid_rst_pc_write", 8'(pc_write_o), 8'd1);
      checkOutput("mid_rst_ifid_write", 8'(ifid_write_o), 8'd1);
      checkOutput("mid_rst_bubble", 8'(idex_bubble_o), 8'd0);
      rst_i = 1'b0;
      stepClock();
      applyStimulus(1, 3, 1, 18, 1, 0, 0);
      checkOutput("post_rst_flush", 8'(flush_o), 8'd0);
      stepClock();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_fwd_a", 8'(fwd_a_sel_o), 8'd0);
      stepClock();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
